miyajiro_mem_arbiter: RTL and testbench

- Shares one single-ported memory between the CPU's instruction-fetch unit (read-only) and its load/store unit (read/write).
- Accepts one request at a time, drives it onto the memory port, waits for the response, and routes the response back to its owner.
- Data accesses have priority over fetches; a starvation counter guarantees fetch progress.
- Sits between the MIYAJIRO_CPU pipeline front/back ends and the memory model.

---
 rtl/miyajiro_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_miyajiro_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/miyajiro_mem_arbiter.sv
// miyajiro_mem_arbiter: shares one single-ported memory between instruction fetch and load/store.
// Data requests win by default; a starvation counter forces fetch through after MAX_IF_WAIT losses.
// One transaction is outstanding at a time: IDLE (arbitrate) -> REQ (drive memory) -> RESP (await rvalid).
// Optional MEM_ARB_TIMEOUT_EN: a stalled response is completed with err=1 after TIMEOUT cycles in RESP.
module miyajiro_mem_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_IF_WAIT = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    output logic            if_err,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            d_err,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata
);
    localparam int SW = DW / 8;
    localparam int CW = $clog2(MAX_IF_WAIT + 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [SW-1:0] wstrb_q;
    logic          if_rvalid_q, d_rvalid_q, if_err_q, d_err_q;
    logic [DW-1:0] if_rdata_q, d_rdata_q;
    logic          force_if, d_win, grant, resp, tmo;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q;
    // Count cycles spent waiting in RESP; restarts on every entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) tmo_q <= '0;
        else          tmo_q <= (state_q == RESP) ? tmo_q + TW'(1) : '0;
    end
    assign tmo = (state_q == RESP) && !mem_rvalid && (tmo_q == TW'(TIMEOUT - 1));
`else
    assign tmo = 1'b0;
`endif

    // Arbitration: data wins unless fetch has already lost MAX_IF_WAIT times in a row
    always_comb begin
        force_if = if_req && (cnt_q == CW'(MAX_IF_WAIT));
        d_win    = d_req && !force_if;
        if_gnt   = reset_n && (state_q == IDLE) && if_req && !d_win;
        d_gnt    = reset_n && (state_q == IDLE) && d_win;
        grant    = if_gnt || d_gnt;
        resp     = (state_q == RESP) && (mem_rvalid || tmo);
    end

    // Starvation counter: bump when data beats a waiting fetch, clear when fetch wins or stops asking
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE)
            cnt_d = (!if_req || if_gnt) ? '0 :
                    (d_gnt && cnt_q != CW'(MAX_IF_WAIT)) ? cnt_q + CW'(1) : cnt_q;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant ? REQ : IDLE;
            REQ:     state_d = mem_gnt ? RESP : REQ;
            RESP:    state_d = resp ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    // Outputs: memory port driven from the latched request, responses from their registers
    always_comb begin
        mem_req   = (state_q == REQ);
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wstrb = wstrb_q;
        if_rvalid = if_rvalid_q;
        if_rdata  = if_rdata_q;
        if_err    = if_err_q;
        d_rvalid  = d_rvalid_q;
        d_rdata   = d_rdata_q;
        d_err     = d_err_q;
    end

    // Latch the winner's request at the handshake and register the response for its owner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_err_q    <= 1'b0;
            d_err_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            cnt_q       <= cnt_d;
            if_rvalid_q <= resp && !owner_q;
            d_rvalid_q  <= resp && owner_q;
            if_err_q    <= tmo && !owner_q;
            d_err_q     <= tmo && owner_q;
            if (grant) begin
                owner_q <= d_win;
                we_q    <= d_win && d_we;
                addr_q  <= d_win ? d_addr : if_addr;
                wdata_q <= d_win ? d_wdata : '0;
                wstrb_q <= (d_win && d_we) ? d_wstrb : '0;
            end
            if (resp && !owner_q) if_rdata_q <= mem_rvalid ? mem_rdata : '0;
            if (resp && owner_q)  d_rdata_q  <= mem_rvalid ? mem_rdata : '0;
        end
    end
endmodule

// File: tb/tb_miyajiro_mem_arbiter.sv
// tb_miyajiro_mem_arbiter: directed vectors plus hand-written multi-cycle sequences for the arbiter.
module tb_miyajiro_mem_arbiter;
    logic        clk = 1'b0, reset_n = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic [3:0]  d_wstrb = '0;
    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err;
    logic [31:0] if_rdata, d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          n_tests = 0, n_fail = 0;

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req, d_we;
        logic [31:0] d_addr, d_wdata;
        logic [3:0]  d_wstrb;
        logic [31:0] rdata;
        logic        e_if, e_d, e_we;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wstrb;
    } vec_t;

    vec_t vecs[6];

    miyajiro_mem_arbiter #(.AW(32), .DW(32), .MAX_IF_WAIT(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One full transaction from IDLE with immediate mem_gnt and rvalid one cycle later
    task automatic do_txn(input vec_t v);
        @(negedge clk);
        if_req = v.if_req; if_addr = v.if_addr;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata; d_wstrb = v.d_wstrb;
        #1;
        chk("if_gnt", 32'(if_gnt), 32'(v.e_if));
        chk("d_gnt", 32'(d_gnt), 32'(v.e_d));
        chk("mem_req_idle", 32'(mem_req), 0);
        @(negedge clk);
        if_req = 1'b0; d_req = 1'b0;
        chk("mem_req", 32'(mem_req), 1);
        chk("mem_we", 32'(mem_we), 32'(v.e_we));
        chk("mem_addr", mem_addr, v.e_addr);
        chk("mem_wstrb", 32'(mem_wstrb), 32'(v.e_wstrb));
        if (v.e_we) chk("mem_wdata", mem_wdata, v.e_wdata);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("mem_req_resp", 32'(mem_req), 0);
        mem_rvalid = 1'b1; mem_rdata = v.rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("if_rvalid", 32'(if_rvalid), 32'(v.e_if));
        chk("d_rvalid", 32'(d_rvalid), 32'(v.e_d));
        chk("err", 32'({if_err, d_err}), 0);
        if (v.e_if) chk("if_rdata", if_rdata, v.rdata);
        if (v.e_d && !v.e_we) chk("d_rdata", d_rdata, v.rdata);
        @(negedge clk);
        chk("rvalid_pulse", 32'({if_rvalid, d_rvalid}), 0);
    endtask

    initial begin
        //          ifr  if_addr       dr    we    d_addr        d_wdata       strb   rdata         eif   ed    ewe   e_addr        e_wdata       e_strb
        vecs[0] = '{1'b1, 32'h100,      1'b0, 1'b0, 32'h0,        32'h0,        4'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 32'h100,      32'h0,        4'h0};
        vecs[1] = '{1'b1, 32'h104,      1'b1, 1'b1, 32'h200,      32'h12345678, 4'hF, 32'h0,        1'b0, 1'b1, 1'b1, 32'h200,      32'h12345678, 4'hF};
        vecs[2] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h300,      32'h5555AAAA, 4'hA, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 32'h300,      32'h0,        4'h0};
        vecs[3] = '{1'b1, 32'h500,      1'b1, 1'b0, 32'h404,      32'h0,        4'hF, 32'h0BADF00D, 1'b0, 1'b1, 1'b0, 32'h404,      32'h0,        4'h0};
        vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       32'hA5A5A5A5, 4'h3, 32'h0,        1'b0, 1'b1, 1'b1, 32'h10,       32'hA5A5A5A5, 4'h3};
        vecs[5] = '{1'b1, 32'hFFFFFFFC, 1'b0, 1'b1, 32'h0,        32'h0,        4'hF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        4'h0};

        // Reset: outputs quiet even with both requests asserted
        if_req = 1'b1; d_req = 1'b1;
        #1;
        chk("rst_if_gnt", 32'(if_gnt), 0);
        chk("rst_d_gnt", 32'(d_gnt), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_rvalid", 32'({if_rvalid, d_rvalid, if_err, d_err}), 0);
        chk("rst_rdata", if_rdata | d_rdata, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1; if_req = 1'b0; d_req = 1'b0;

        for (int i = 0; i < 6; i++) do_txn(vecs[i]);

        // Write beats fetch; fetch granted in the same cycle as the write ack
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678; d_wstrb = 4'hF;
        #1;
        chk("sim_d_gnt", 32'(d_gnt), 1);
        chk("sim_if_gnt", 32'(if_gnt), 0);
        @(negedge clk);
        d_req = 1'b0;
        chk("sim_no_gnt_req", 32'(if_gnt), 0);
        chk("sim_mem_we", 32'(mem_we), 1);
        chk("sim_mem_wstrb", 32'(mem_wstrb), 32'hF);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        chk("sim_wr_ack", 32'(d_rvalid), 1);
        chk("sim_if_gnt_after", 32'(if_gnt), 1);
        @(negedge clk);
        if_req = 1'b0;
        chk("sim_if_addr", mem_addr, 32'h104);
        chk("sim_if_we", 32'(mem_we), 0);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("sim_if_rvalid", 32'(if_rvalid), 1);
        chk("sim_if_rdata", if_rdata, 32'h55AA55AA);

        // Starvation: both held high -> d,d,d,d,if repeating
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h700;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("starve_d_gnt", 32'(d_gnt), 32'((i % 5) != 4));
            chk("starve_if_gnt", 32'(if_gnt), 32'((i % 5) == 4));
            @(negedge clk);
            chk("starve_addr", mem_addr, ((i % 5) == 4) ? 32'h700 : 32'h600);
            mem_gnt = 1'b1;
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'(i);
            @(negedge clk);
            mem_rvalid = 1'b0;
        end
        if_req = 1'b0; d_req = 1'b0;

        // Back-pressure: mem_gnt low 5 cycles, fields stable, no grants despite new requests
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h800; d_wdata = 32'h11223344; d_wstrb = 4'hC;
        #1;
        chk("bp_d_gnt", 32'(d_gnt), 1);
        @(negedge clk);
        if_req = 1'b1; d_addr = 32'h900; d_wdata = 32'h0; d_wstrb = 4'h1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("bp_mem_req", 32'(mem_req), 1);
            chk("bp_mem_addr", mem_addr, 32'h800);
            chk("bp_mem_wdata", mem_wdata, 32'h11223344);
            chk("bp_mem_wstrb", 32'(mem_wstrb), 32'hC);
            chk("bp_no_gnt", 32'({if_gnt, d_gnt}), 0);
            if (k == 5) mem_gnt = 1'b1;
            @(negedge clk);
        end
        mem_gnt = 1'b0; if_req = 1'b0; d_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("bp_d_rvalid", 32'(d_rvalid), 1);

        // Reset while waiting in RESP; late rvalid ignored
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        #1;
        chk("rr_d_gnt", 32'(d_gnt), 1);
        @(negedge clk);
        d_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0; reset_n = 1'b0; if_req = 1'b1;
        #1;
        chk("rr_mem_req", 32'(mem_req), 0);
        chk("rr_if_gnt", 32'(if_gnt), 0);
        chk("rr_d_rdata", d_rdata, 0);
        chk("rr_if_rdata", if_rdata, 0);
        @(negedge clk);
        reset_n = 1'b1; if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h99;
        @(negedge clk);
        mem_rvalid = 1'b0;
        chk("rr_late_rvalid", 32'({if_rvalid, d_rvalid}), 0);
        chk("rr_late_rdata", d_rdata, 0);
        chk("rr_idle_mem_req", 32'(mem_req), 0);
        do_txn(vecs[0]);

`ifdef MEM_ARB_TIMEOUT_EN
        // Timeout: memory never responds -> error response 8 cycles after entering RESP
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        @(negedge clk);
        d_req = 1'b0; mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("to_wait", 32'(d_rvalid), 0);
            @(negedge clk);
        end
        chk("to_rvalid", 32'(d_rvalid), 1);
        chk("to_err", 32'(d_err), 1);
        chk("to_rdata", d_rdata, 0);
        chk("to_idle", 32'(mem_req), 0);
        @(negedge clk);
        chk("to_pulse", 32'(d_rvalid), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
